// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and types for the pipelined CLA adder/subtractor.
// Flag ordering {ovf,cout,zero} matches what the ALU result mux expects.
package cla_pipe_adder_pkg;
    localparam int GROUP_W   = 4;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_OVF  = 2;

    typedef struct packed {
        logic ovf;
        logic cout;
        logic zero;
    } flags_t;

    // Sum bits resolved by one stage.
    function automatic int slice_w(int gps);
        return GROUP_W * gps;
    endfunction

    function automatic int nstage(int width, int gps);
        return width / (GROUP_W * gps);
    endfunction

    // Depth of operand/carry stage registers; the last stage needs none.
    function automatic int carry_depth(int width, int gps);
        return (nstage(width, gps) > 1) ? nstage(width, gps) - 1 : 1;
    endfunction
endpackage

// File: rtl/cla_pipe_adder_group.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate,
// and the carry into bit 3 so the top can form signed overflow.
module cla_group
    import cla_pipe_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               g,
    output logic               p,
    output logic               c3
);
    logic [GROUP_W-1:0] gi;
    logic [GROUP_W-1:0] pi;
    logic [GROUP_W-1:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);

    assign sum = pi ^ c;
    assign g   = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
               | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p   = &pi;
    assign c3  = c[3];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: each stage resolves GPS 4-bit groups and
// registers its carry; a single global stall freezes every stage together.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW     = slice_w(GPS);
    localparam int NSTAGE = nstage(WIDTH, GPS);
    localparam int PD     = carry_depth(WIDTH, GPS);
    localparam int L      = NSTAGE - 1;

    logic advance;

    logic [NSTAGE-1:0]             vld_pipe;
    logic [NSTAGE-1:0][WIDTH-1:0]  s_pipe;
    logic [PD-1:0]                 c_pipe;
    logic [PD-1:0][WIDTH-1:0]      a_pipe;
    logic [PD-1:0][WIDTH-1:0]      b_pipe;
    flags_t                        flags_q;
    flags_t                        flags_d;

    // Per-stage view of its inputs, and its outputs before registering.
    logic [NSTAGE-1:0]             st_v;
    logic [NSTAGE-1:0]             st_c;
    logic [NSTAGE-1:0][WIDTH-1:0]  st_a;
    logic [NSTAGE-1:0][WIDTH-1:0]  st_b;
    logic [NSTAGE-1:0][WIDTH-1:0]  st_s;
    logic [NSTAGE-1:0][WIDTH-1:0]  ns;
    logic [NSTAGE-1:0][SW-1:0]     rs;
    logic [NSTAGE-1:0][GPS:0]      gc;
    logic [NSTAGE-1:0][GPS-1:0]    gg;
    logic [NSTAGE-1:0][GPS-1:0]    gp;
    logic [NSTAGE-1:0][GPS-1:0]    gc3;

    assign advance   = !vld_pipe[L] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[L];
    assign sum       = s_pipe[L];
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction folds into stage 0: invert B once, force carry-in.
            assign st_v[k] = in_valid;
            assign st_a[k] = a;
            assign st_b[k] = sub ? ~b : b;
            assign st_c[k] = sub | cin;
            assign st_s[k] = '0;
        end else begin : g_next
            assign st_v[k] = vld_pipe[k-1];
            assign st_a[k] = a_pipe[k-1];
            assign st_b[k] = b_pipe[k-1];
            assign st_c[k] = c_pipe[k-1];
            assign st_s[k] = s_pipe[k-1];
        end

        assign gc[k][0] = st_c[k];

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            localparam int LO = k*SW + j*GROUP_W;
            cla_group u_grp (
                .a   (st_a[k][LO +: GROUP_W]),
                .b   (st_b[k][LO +: GROUP_W]),
                .cin (gc[k][j]),
                .sum (rs[k][j*GROUP_W +: GROUP_W]),
                .g   (gg[k][j]),
                .p   (gp[k][j]),
                .c3  (gc3[k][j])
            );
            assign gc[k][j+1] = gg[k][j] | (gp[k][j] & gc[k][j]);
        end

        // Slice k of the partial sum is still zero here, so OR merges it in.
        assign ns[k] = st_s[k] | (WIDTH'(rs[k]) << (k*SW));
    end

    always_comb begin
        flags_d      = '0;
        flags_d.cout = gc[L][GPS];
        flags_d.ovf  = gc3[L][GPS-1] ^ gc[L][GPS];
        flags_d.zero = (ns[L] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s_pipe   <= '0;
            c_pipe   <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
            flags_q  <= '0;
        end else if (advance) begin
            vld_pipe <= st_v;
            s_pipe   <= ns;
            flags_q  <= flags_d;
            for (int k = 0; k < NSTAGE - 1; k++) begin
                c_pipe[k] <= gc[k][GPS];
                a_pipe[k] <= st_a[k];
                b_pipe[k] <= st_b[k];
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: a 32-bit/GPS=2 and a 16-bit/GPS=1 instance share the
// handshake; expected results are queued at acceptance and popped on delivery.
module tb_cla_pipe_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q32[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .GPS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_adder #(.WIDTH(16), .GPS(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide addition of masked operands.
    function automatic exp_t model(input int w, input logic [31:0] va, input logic [31:0] vb,
                                   input logic vs, input logic vc);
        logic [32:0] r;
        logic [31:0] m, bb, aa;
        exp_t        e;
        m      = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        aa     = va & m;
        bb     = (vs ? ~vb : vb) & m;
        r      = {1'b0, aa} + {1'b0, bb} + 33'(vs | vc);
        e.sum  = r[31:0] & m;
        e.cout = r[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        e.zero = (e.sum == 32'h0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                                input logic vc, input logic [31:0] s, input logic co,
                                input logic ov, input logic z);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.cin = vc;
        v.e.sum = s; v.e.cout = co; v.e.ovf = ov; v.e.zero = z;
        return v;
    endfunction

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input logic vc, input exp_t e, output int waits);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; a = va; b = vb; sub = vs; cin = vc;
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                q32.push_back(e);
                q16.push_back(model(16, va, vb, vs, vc));
                break;
            end
            waits++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q32.size() == 0 && q16.size() == 0) break;
        end
        check("drain", 64'(q32.size() + q16.size()), 64'd0);
    endtask

    // Monitors: compare on delivery; while stalled the head must be on the bus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q32.size() == 0) check("spurious32", 64'd1, 64'd0);
                else if (!out_ready) check("hold32", 64'({sum, cout, ovf, zero}), 64'(q32[0]));
                else begin
                    e = q32.pop_front();
                    check("result32", 64'({sum, cout, ovf, zero}), 64'(e));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid16) begin
                if (q16.size() == 0) check("spurious16", 64'd1, 64'd0);
                else if (!out_ready) check("hold16", 64'({16'h0, sum16, cout16, ovf16, zero16}), 64'(q16[0]));
                else begin
                    e = q16.pop_front();
                    check("result16", 64'({16'h0, sum16, cout16, ovf16, zero16}), 64'(e));
                end
            end
        end
    end

    initial begin
        vec_t        dir[8];
        int          w, stalls, n, seen;
        logic [31:0] ra, rb;
        logic        rs, rc;

        dir[0] = mk(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        dir[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        dir[2] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        dir[3] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        dir[4] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        dir[5] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        dir[6] = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
        dir[7] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Reset state
        @(negedge clk);
        check("reset32", 64'({out_valid, sum, cout, ovf, zero}), 64'd0);
        check("reset16", 64'({out_valid16, sum16, cout16, ovf16, zero16}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'({in_ready, in_ready16}), 64'b11);

        // Single beat, latency measured in cycles from presentation
        @(posedge clk); #1;
        send(dir[0].a, dir[0].b, dir[0].sub, dir[0].cin, dir[0].e, w);
        idle();
        n = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n = i;
            if (out_valid) break;
        end
        check("latency", 64'(n), 64'd4);
        drain();

        // Remaining directed vectors back to back
        @(posedge clk); #1;
        for (int i = 1; i < 8; i++) send(dir[i].a, dir[i].b, dir[i].sub, dir[i].cin, dir[i].e, w);
        idle();
        drain();

        // Random stream at full rate
        stalls = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, model(32, ra, rb, rs, rc), w);
            stalls += w;
        end
        idle();
        check("in_ready_stream", 64'(stalls), 64'd0);
        drain();

        // Backpressure with a full pipe
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, rc, model(32, ra, rb, rs, rc), w);
                end
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("in_ready_stall", 64'({in_ready, in_ready16}), 64'b00);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Async reset with beats in flight
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom;
            send(ra, rb, 1'b0, 1'b0, model(32, ra, rb, 1'b0, 1'b0), w);
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("reset_drop_valid", 64'({out_valid, out_valid16}), 64'b00);
        q32.delete();
        q16.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || out_valid16) seen++;
        end
        check("no_stale_beats", 64'(seen), 64'd0);

        // Pipe still works after the mid-stream reset
        @(posedge clk); #1;
        send(dir[3].a, dir[3].b, dir[3].sub, dir[3].cin, dir[3].e, w);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor: next generation of our 4-bit CLA.
- WIDTH-bit operands are split into 4-bit CLA groups. Each pipeline stage resolves GPS groups, and the carry is registered between stages.
- Valid/ready handshake on both sides. Produces sum, carry-out, signed overflow and zero flags.
- Sits between the operand-fetch register and the ALU result mux in the datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4*GPS.
- GPS, 2, 4-bit groups resolved per pipeline stage.
- NSTAGE, derived = WIDTH/(4*GPS), pipeline depth; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B+cin, 1 = A-B (B inverted, cin forced 1).
- cin  in  1  carry-in; used only when sub=0.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR cout.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async, rst_n=0): every stage valid bit clears to 0; all data and carry registers clear to 0. Outputs read out_valid=0, sum=0, cout=0, ovf=0, zero=0. Deassertion is sampled synchronously; in_ready=1 on the first cycle after release.
- Handshake: accept when in_valid && in_ready; deliver when out_valid && out_ready. Data and flags are held stable while out_valid && !out_ready.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - All stage registers load only when advance=1.
  - Bubbles propagate as valid=0 and are not compressed.
- Latency: exactly NSTAGE cycles from acceptance to out_valid with out_ready held 1. Throughput is one beat per cycle.
- Stage k (0..NSTAGE-1):
  - Takes registered carry c_k (stage 0 uses cin_eff = sub ? 1 : cin; b_eff = sub ? ~b : b).
  - Computes sum bits [4*GPS*k +: 4*GPS] using GPS cla_group instances.
  - Inter-group carries within a stage use lookahead: c_{j+1} = G_j | P_j&c_j.
- Operand skew: unresolved upper operand slices are carried forward in stage registers. Resolved sum slices are carried forward so the final stage presents the full sum aligned.
- Flags are computed in the last stage from the final group's internal carries and registered with sum. ovf uses the carry into bit WIDTH-1.
- Wrap-around: sum is modulo 2^WIDTH; overflow is reported only via cout/ovf.
- Simultaneous accept and deliver in one cycle with a full pipe is legal and keeps one beat per cycle.
- Reset mid-operation: all in-flight beats are discarded with no partial output.
- in_valid, a and b are ignored when in_ready=0; an upstream hold is the caller's duty.
- sub and cin are captured at acceptance and travel with the beat.

Decomposition:
- Shared package/header:
  - GROUP_W=4 constant.
  - Stage-register field widths as localparam functions of WIDTH/GPS.
  - Flag bit ordering {ovf,cout,zero} for the ALU result mux.
- Sub-module cla_group:
  - Inputs a[3:0], b[3:0], cin.
  - Outputs sum[3:0], group G, group P, c3 (carry into bit 3, needed for ovf).
  - Built on the existing fa and cll_4bit modules.
- Top-level: a generate loop over stages and groups.

Test Plan:
- Reset then single add, WIDTH=32, GPS=2: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, out_ready=1 -> after 4 cycles sum=0, cout=1, ovf=0, zero=1.
- Signed overflow add: a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, cout=0. Sub: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Back-to-back stream: 20 random beats with in_valid=1 and out_ready=1 -> one result per cycle, in order, all matching the reference model; in_ready stays 1.
- Backpressure:
  - Drop out_ready for 3 cycles with a full pipe -> in_ready=0, sum held stable, no beat lost or duplicated.
  - Release -> order preserved.
- cin carry chain: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1 (carry crosses every stage register). Same with sub=1 and cin=1 -> cin is ignored.
- Async reset asserted mid-stream with 3 beats in flight -> out_valid drops immediately, no stale beats after release. Repeat with WIDTH=16, GPS=1.
